// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and branch-predictor counter helpers.
package cpu_pkg;

  localparam logic [3:0] OPC_BRANCH = 4'b0010;
  localparam logic [3:0] OPC_ALU_R  = 4'b1100;
  localparam logic [3:0] OPC_ALU_I  = 4'b0100;

  // Weakly-not-taken value of a ctr_bits-wide saturating counter (0 when ctr_bits == 1).
  function automatic int unsigned weak_not_taken(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup / execute-resolve bundle of the branch prediction unit.
// Optional performance counters present when PERF_CNT_EN is defined.
interface branch_predict_unit_if #(
  parameter int unsigned DBITS = 32
);
  logic [DBITS-1:0] IF_PC;
  logic             IF_prediction;
  logic             EX_valid;
  logic [3:0]       EX_opcode;
  logic [DBITS-1:0] EX_branchPC;
  logic [DBITS-1:0] EX_PC;
  logic [DBITS-1:0] EX_PC_IMM;
  logic             EX_condFlag;
  logic             EX_prediction;
  logic             correctOut;
  logic             flush;
  logic [DBITS-1:0] newPC;
`ifdef PERF_CNT_EN
  logic [31:0]      perfBranches;
  logic [31:0]      perfMispredicts;

  modport master (
    output IF_PC, EX_valid, EX_opcode, EX_branchPC, EX_PC, EX_PC_IMM, EX_condFlag, EX_prediction,
    input  IF_prediction, correctOut, flush, newPC, perfBranches, perfMispredicts
  );
  modport slave (
    input  IF_PC, EX_valid, EX_opcode, EX_branchPC, EX_PC, EX_PC_IMM, EX_condFlag, EX_prediction,
    output IF_prediction, correctOut, flush, newPC, perfBranches, perfMispredicts
  );
`else
  modport master (
    output IF_PC, EX_valid, EX_opcode, EX_branchPC, EX_PC, EX_PC_IMM, EX_condFlag, EX_prediction,
    input  IF_prediction, correctOut, flush, newPC
  );
  modport slave (
    input  IF_PC, EX_valid, EX_opcode, EX_branchPC, EX_PC, EX_PC_IMM, EX_condFlag, EX_prediction,
    output IF_prediction, correctOut, flush, newPC
  );
`endif
endinterface

// File: rtl/bht_counter_table.sv
// Table of saturating direction counters: one combinational read port, one
// read-modify-write training port, synchronous reset to weakly-not-taken.
module bht_counter_table
  import cpu_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_taken,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int unsigned         ENTRIES  = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_not_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] cur_c;
  logic [CTR_BITS-1:0] nxt_c;

  // No bypass: a same-cycle write is seen by the read port only after the edge.
  assign rd_taken = ctr_q[rd_idx][CTR_BITS-1];

  // Saturating step toward the resolved direction.
  always_comb begin
    cur_c = ctr_q[wr_idx];
    nxt_c = cur_c;
    if (wr_taken) begin
      if (cur_c != CTR_MAX) nxt_c = cur_c + 1'b1;
    end else begin
      if (cur_c != '0) nxt_c = cur_c - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[IDX_BITS'(i)] <= CTR_INIT;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= nxt_c;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction (fetch lookup) and resolution (execute) unit with counter-table training.
// Define PERF_CNT_EN to add saturating branch / mispredict counters.
module branch_predict_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned CTR_BITS  = 2,
  parameter logic [3:0]  OP_BRANCH = OPC_BRANCH
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predict_unit_if.slave bus
);

  logic                resolve_c;
  logic [IDX_BITS-1:0] if_idx_c;
  logic [IDX_BITS-1:0] ex_idx_c;
  logic                unused_pc_bits_c;

  assign if_idx_c  = bus.IF_PC[IDX_BITS+1:2];
  assign ex_idx_c  = bus.EX_branchPC[IDX_BITS+1:2];
  assign resolve_c = bus.EX_valid && (bus.EX_opcode == OP_BRANCH);

  // Only the word-index bits of the PCs address the table.
  assign unused_pc_bits_c = ^{bus.IF_PC[DBITS-1:IDX_BITS+2], bus.IF_PC[1:0],
                              bus.EX_branchPC[DBITS-1:IDX_BITS+2], bus.EX_branchPC[1:0]};

  bht_counter_table #(
    .IDX_BITS (IDX_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_idx_c),
    .rd_taken (bus.IF_prediction),
    .wr_en    (resolve_c),
    .wr_idx   (ex_idx_c),
    .wr_taken (bus.EX_condFlag)
  );

  // Zero-latency resolution; idle or non-branch slots fall through to EX_PC.
  always_comb begin
    bus.correctOut = 1'b1;
    bus.flush      = 1'b0;
    bus.newPC      = bus.EX_PC;
    if (resolve_c) begin
      bus.correctOut = (bus.EX_prediction == bus.EX_condFlag);
      bus.flush      = (bus.EX_prediction != bus.EX_condFlag);
      bus.newPC      = bus.EX_condFlag ? bus.EX_PC_IMM : bus.EX_PC;
    end
  end

`ifdef PERF_CNT_EN
  localparam logic [31:0] PERF_MAX = '1;

  logic [31:0] perf_br_q;
  logic [31:0] perf_mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else if (resolve_c) begin
      if (perf_br_q != PERF_MAX) perf_br_q <= perf_br_q + 32'd1;
      if (bus.flush && (perf_mis_q != PERF_MAX)) perf_mis_q <= perf_mis_q + 32'd1;
    end
  end

  assign bus.perfBranches    = perf_br_q;
  assign bus.perfMispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a reference counter-table model
// feeds a scoreboard queue that is popped and compared each EX cycle.
module tb_branch_predict_unit;

  localparam logic [3:0] OP_BR  = 4'b0010;
  localparam logic [3:0] OP_ALU = 4'b1100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.DBITS(32)) bus ();

  branch_predict_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected {IF_prediction, correctOut, flush, newPC}
  logic [34:0] sb[$];
  logic [1:0]  model [64];
  int unsigned m_br;
  int unsigned m_mis;
  int n_cmp = 0;
  int n_bad = 0;

  // Drive one EX/IF cycle after negedge, push expectation, advance model to the next edge.
  task automatic drive(input logic r, input logic [31:0] ifpc, input logic v, input logic [3:0] op,
                       input logic [31:0] bpc, input logic [31:0] pc, input logic [31:0] imm,
                       input logic cond, input logic pred);
    logic        res;
    logic [34:0] e;
    logic [5:0]  wi;
    @(negedge clk);
    reset             = r;
    bus.IF_PC         = ifpc;
    bus.EX_valid      = v;
    bus.EX_opcode     = op;
    bus.EX_branchPC   = bpc;
    bus.EX_PC         = pc;
    bus.EX_PC_IMM     = imm;
    bus.EX_condFlag   = cond;
    bus.EX_prediction = pred;
    res     = v && (op == OP_BR);
    e[34]   = model[ifpc[7:2]][1];
    e[33]   = res ? (pred == cond) : 1'b1;
    e[32]   = res ? (pred != cond) : 1'b0;
    e[31:0] = (res && cond) ? imm : pc;
    sb.push_back(e);
    wi = bpc[7:2];
    if (r) begin
      for (int i = 0; i < 64; i++) model[i] = 2'b01;
      m_br  = 0;
      m_mis = 0;
    end else if (res) begin
      if (cond && model[wi] != 2'b11) model[wi] = model[wi] + 2'b01;
      else if (!cond && model[wi] != 2'b00) model[wi] = model[wi] - 2'b01;
      m_br++;
      if (pred != cond) m_mis++;
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    drive(1'b0, ifpc, 1'b0, OP_ALU, 32'h0, 32'h104, 32'h200, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [34:0] e;
    logic [34:0] act;
    drive(1'b1, 32'h10, 1'b0, OP_ALU, 32'h0, 32'h14, 32'h40, 1'b0, 1'b0);
    e   = sb.pop_front();
    act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
    n_cmp++;
    if (act[33:0] !== e[33:0]) begin
      n_bad++;
      $display("FAIL reset_cycle_outputs: got %h expected %h", act[33:0], e[33:0]);
    end
    foreach (model[i]) model[i] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      idle(32'h10 + 32'(k * 4));
      e   = sb.pop_front();
      act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL reset_lookup[%0d]: got %h expected %h", k, act, e);
      end
    end
  endtask

  task automatic test_mispredict();
    logic [34:0] e;
    logic [34:0] act;
    drive(1'b0, 32'h20, 1'b1, OP_BR, 32'h10, 32'h14, 32'h40, 1'b1, 1'b0);
    e   = sb.pop_front();
    act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
    n_cmp++;
    if (act !== e || act[33:0] !== {2'b01, 32'h40}) begin
      n_bad++;
      $display("FAIL mispredict_taken: got %h expected %h", act, e);
    end
    idle(32'h10);
    e   = sb.pop_front();
    act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
    n_cmp++;
    if (act !== e || act[34] !== 1'b1) begin
      n_bad++;
      $display("FAIL trained_lookup: got %h expected %h", act, e);
    end
  endtask

  task automatic test_saturate();
    logic [34:0] e;
    logic [34:0] act;
    logic        cond_t[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      if (k < 5) drive(1'b0, 32'h10, 1'b1, OP_BR, 32'h10, 32'h14, 32'h40, cond_t[k], 1'b1);
      else idle(32'h10);
      e   = sb.pop_front();
      act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL saturate_step[%0d]: got %h expected %h", k, act, e);
      end
    end
  endtask

  task automatic test_bubble();
    logic [34:0] e;
    logic [34:0] act;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive(1'b0, 32'h10, 1'b0, OP_BR, 32'h10, 32'h14, 32'h40, 1'b1, 1'b0);
        1: drive(1'b0, 32'h10, 1'b1, OP_ALU, 32'h10, 32'h14, 32'h40, 1'b1, 1'b0);
        default: idle(32'h10);
      endcase
      e   = sb.pop_front();
      act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL bubble_step[%0d]: got %h expected %h", k, act, e);
      end
    end
  endtask

  task automatic test_same_index();
    logic [34:0] e;
    logic [34:0] act;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive(1'b0, 32'h30, 1'b1, OP_BR, 32'h30, 32'h34, 32'h80, 1'b1, 1'b0);
      else idle(32'h30);
      e   = sb.pop_front();
      act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
      n_cmp++;
      if (act !== e || act[34] !== k[0]) begin
        n_bad++;
        $display("FAIL same_index[%0d]: got %h expected %h", k, act, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] e;
    logic [34:0] act;
    logic [31:0] ifpc;
    logic [31:0] bpc;
    for (int k = 0; k < 60; k++) begin
      ifpc = 32'h100 + 32'($urandom_range(0, 3) * 4);
      bpc  = 32'h100 + 32'($urandom_range(0, 3) * 4);
      drive(1'b0, ifpc, 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0) ? OP_BR : OP_ALU,
            bpc, bpc + 32'd4, 32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      e   = sb.pop_front();
      act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", k, act, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [34:0] e;
    logic [34:0] act;
    for (int k = 0; k < 3; k++) drive(1'b0, 32'h8, 1'b1, OP_BR, 32'h8, 32'hC, 32'h60, 1'b1, 1'b0);
    repeat (3) void'(sb.pop_front());
    // Branch resolving in the reset cycle: outputs still resolve, training is lost.
    drive(1'b1, 32'h8, 1'b1, OP_BR, 32'h8, 32'hC, 32'h60, 1'b1, 1'b0);
    e   = sb.pop_front();
    act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
    n_cmp++;
    if (act !== e || act[34] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_cycle: got %h expected %h", act, e);
    end
    for (int k = 0; k < 4; k++) begin
      idle(32'h8 + 32'(k * 4));
      e   = sb.pop_front();
      act = {bus.IF_prediction, bus.correctOut, bus.flush, bus.newPC};
      n_cmp++;
      if (act !== e || act[34] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_lookup[%0d]: got %h expected %h", k, act, e);
      end
    end
  endtask

`ifdef PERF_CNT_EN
  task automatic test_perf();
    logic pred_t[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic cond_t[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    idle(32'h0);
    void'(sb.pop_front());
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b1, OP_BR, 32'h40 + 32'(k * 4), 32'h44, 32'h90, cond_t[k], pred_t[k]);
      void'(sb.pop_front());
    end
    drive(1'b0, 32'h0, 1'b0, OP_BR, 32'h40, 32'h44, 32'h90, 1'b1, 1'b0);
    void'(sb.pop_front());
    n_cmp++;
    if (bus.perfBranches !== 32'd5 || bus.perfBranches !== 32'(m_br)) begin
      n_bad++;
      $display("FAIL perf_branches: got %0d expected 5", bus.perfBranches);
    end
    n_cmp++;
    if (bus.perfMispredicts !== 32'd2 || bus.perfMispredicts !== 32'(m_mis)) begin
      n_bad++;
      $display("FAIL perf_mispredicts: got %0d expected 2", bus.perfMispredicts);
    end
    drive(1'b1, 32'h0, 1'b1, OP_BR, 32'h40, 32'h44, 32'h90, 1'b1, 1'b0);
    idle(32'h0);
    repeat (2) void'(sb.pop_front());
    n_cmp++;
    if (bus.perfBranches !== 32'd0 || bus.perfMispredicts !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_reset: got %0d/%0d expected 0/0", bus.perfBranches, bus.perfMispredicts);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    foreach (model[i]) model[i] = 2'b01;
    m_br  = 0;
    m_mis = 0;
    test_reset();
    test_mispredict();
    test_saturate();
    test_bubble();
    test_same_index();
    test_back_to_back();
    test_reset_mid();
`ifdef PERF_CNT_EN
    test_perf();
`endif
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch prediction and resolution unit for the 5-stage pipeline. Fetch looks up a direction prediction in a table of saturating counters indexed by PC. Execute resolves each branch against its carried prediction and raises correct, flush and redirect PC. The resolved outcome then trains the table. It replaces the single-bit, stateless branch handler; its resolution outputs keep the same meaning.

## Interface
Parameters:
- DBITS, 32, PC/data width
- IDX_BITS, 6, counter-table index width (2^IDX_BITS entries)
- CTR_BITS, 2, saturating counter width (≥1)
- OP_BRANCH, 4'b0010, opcode value identifying a conditional branch

Ports (clock `clk`; reset `reset`, synchronous, active-high, one clock domain):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- IF_PC  in  DBITS  fetch PC for lookup
- IF_prediction  out  1  predicted taken (counter MSB at IF_PC index)
- EX_valid  in  1  EX stage holds a real instruction (0 = bubble)
- EX_opcode  in  4  EX instruction opcode
- EX_branchPC  in  DBITS  address of the EX branch (for table index)
- EX_PC  in  DBITS  fall-through PC of the EX instruction
- EX_PC_IMM  in  DBITS  branch target
- EX_condFlag  in  1  actual outcome (1 = taken)
- EX_prediction  in  1  prediction made at fetch, carried down the pipe
- correctOut  out  1  prediction matched outcome
- flush  out  1  squash younger instructions, redirect fetch
- newPC  out  DBITS  redirect target

## Operation
- Index = PC[IDX_BITS+1:2] (word aligned). IF uses IF_PC; EX uses EX_branchPC.
- Lookup: IF_prediction = table[IF idx][CTR_BITS-1]. It is combinational from the current table contents.
- Resolve is active when EX_valid && EX_opcode==OP_BRANCH:
  - correctOut = (EX_prediction == EX_condFlag)
  - flush = !correctOut
  - newPC = EX_condFlag ? EX_PC_IMM : EX_PC
- When resolve is inactive: correctOut=1, flush=0, newPC=EX_PC.
- Training happens on the rising edge when resolve is active. The counter at the EX index increments if EX_condFlag=1 and decrements if 0.
  - Increment saturates at 2^CTR_BITS-1; decrement saturates at 0. There is no wrap.
  - A training event on a saturated counter leaves it unchanged.
- Only one entry is written per cycle; other entries hold.

## Timing
- correctOut, flush and newPC are combinational in the EX cycle (zero latency).
- A table write becomes visible to IF on the cycle after the edge. If IF and EX hit the same index in the same cycle, IF gets the old value (no bypass).
- Reset, on the edge with reset=1: every counter is set to weakly-not-taken (2^(CTR_BITS-1)-1; 01 for 2 bits). With CTR_BITS=1 every counter is 0.
- Training is suppressed while reset=1. A branch resolving in the reset cycle is lost.
- Outputs during reset follow the combinational rules. IF_prediction reads the pre-reset table until the edge.
- A bubble (EX_valid=0) never trains or flushes, even with opcode==OP_BRANCH.

## Configuration
- PERF_CNT_EN defined: adds outputs perfBranches and perfMispredicts, each 32 bits.
  - perfBranches increments on each resolve.
  - perfMispredicts increments on each resolve with flush=1.
  - Both saturate at 2^32-1 and clear on reset.
- PERF_CNT_EN undefined: these ports and registers are absent. Behaviour is otherwise identical.

## Structure
- Shared package (cpu_pkg): opcode constants (BRANCH 4'b0010, ALU_R 4'b1100, ALU_I 4'b0100) and the weakly-not-taken init constant function.
- Sub-module bht_counter_table: the counter array. It provides one combinational read port (IF), one read-modify-write saturating update port (EX) and a synchronous reset.

## Test plan
- Reset, then IF_PC=0x10 → IF_prediction=0. Counter at idx 4 is 01.
- Branch at EX_branchPC=0x10, EX_PC=0x14, EX_PC_IMM=0x40, pred=0, cond=1 → correctOut=0, flush=1, newPC=0x40. Next cycle IF_PC=0x10 reads prediction 1 (counter 10).
- Same branch, pred=1, cond=1, repeated 3× → flush=0 each time. Counter saturates at 11 and stays 11.
- From counter 11: pred=1, cond=0 → flush=1, newPC=0x14, counter 10, prediction still 1. A second not-taken → counter 01, prediction 0.
- EX_valid=0 with opcode=BRANCH and cond≠pred → flush=0, newPC=EX_PC, table unchanged. Simultaneous IF/EX same index → IF sees the pre-update value.
- PERF_CNT_EN: 5 branches with 2 mispredicts → perfBranches=5, perfMispredicts=2. Reset mid-stream → both 0 and all counters 01.
